// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared constants and types for the sequential BCD-to-binary converter.
//   DEF_DIGITS / DEF_BIN_W : default digit count and binary width
//   BCD_MAX_DIGIT          : largest legal BCD digit value
//   CORR_THRESH            : digit value at or above which 3 is subtracted
//   state_t, ST_IDLE/ST_SHIFT : FSM state type and encodings
//   cnt_width()            : iteration-counter width for a given BIN_W
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int DEF_DIGITS = 3;
  localparam int DEF_BIN_W  = 10;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] CORR_THRESH   = 4'd8;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

  // The counter must be able to hold the value BIN_W.
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_BIN_W);

endpackage

// File: rtl/bcd_to_bin_seq_sub3.sv
// -----------------------------------------------------------------------------
// sub3
// Single-digit corrector for reverse double-dabble: after a right shift, a
// digit that reads 8 or more has picked up a "half ten" (8 instead of 5) from
// the digit above, so 3 is subtracted. Purely combinational, 4-bit, no carry.
//   i_digit : digit after the shift
//   o_digit : corrected digit
// -----------------------------------------------------------------------------
module sub3
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= CORR_THRESH) ? (i_digit - 4'd3) : i_digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_seq
// Iterative BCD-to-binary converter (reverse double-dabble, one bit per clock).
//
// Ports:
//   CLOCK_50  : system clock, rising edge
//   reset     : asynchronous, active-high reset
//   start     : conversion request, only looked at while idle
//   bcd_in    : packed BCD, digit 0 (ones) in [3:0]
//   busy      : conversion in progress
//   done      : one-cycle completion pulse
//   err       : invalid-digit flag, valid with done, held until the next start
//   bin_out   : binary result, held until the next completion
//   dbg_state : current FSM state (ST_IDLE / ST_SHIFT)
//
// Handshake: a request is accepted on any rising edge where the block is idle
// and start=1 (this includes the cycle where done=1). bcd_in is captured on
// that edge only. busy rises after the accepting edge and falls on the edge
// that raises done; busy and done are never high together. start while busy
// is ignored.
//
// Build option: define BCD2BIN_CHECK_EN to flag digits above 9 at capture;
// a flagged conversion still runs all BIN_W steps, then reports err=1 with
// bin_out=0. Without it err is tied low and invalid digits pass through the
// algorithm unchecked.
// -----------------------------------------------------------------------------
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int BIN_W  = DEF_BIN_W
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      bin_out,
  output state_t                dbg_state
);

  localparam int DW    = 4 * DIGITS;
  localparam int CNT_W = cnt_width(BIN_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t             r_state;
  logic [DW-1:0]      r_digits;
  logic [BIN_W-1:0]   r_bin;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [BIN_W-1:0]   r_bin_out;

  logic [DW+BIN_W-1:0] w_shifted;
  logic [DW-1:0]       w_digits_corr;
  logic [BIN_W-1:0]    w_bin_sh;
  logic                w_capture;
  logic                w_finish;
  logic [BIN_W-1:0]    w_result;

  assign w_capture = (r_state == ST_IDLE) && start;
  assign w_finish  = (r_state == ST_SHIFT) && (r_cnt == LAST_CNT);

  // The digit register and the binary register form one long shift chain:
  // the ones digit's LSB falls into the binary MSB on every step.
  assign w_shifted = {r_digits, r_bin} >> 1;
  assign w_bin_sh  = w_shifted[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    sub3 u_sub3 (
      .i_digit (w_shifted[BIN_W + 4*g +: 4]),
      .o_digit (w_digits_corr[4*g +: 4])
    );
  end

`ifdef BCD2BIN_CHECK_EN
  logic r_invalid;
  logic r_err;
  logic w_bad_digit;

  always_comb begin
    w_bad_digit = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_in[4*k +: 4] > BCD_MAX_DIGIT) w_bad_digit = 1'b1;
    end
  end

  // The flag is only latched at capture; the conversion itself is unaffected.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_invalid <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_capture) begin
      r_invalid <= w_bad_digit;
      r_err     <= 1'b0;
    end else if (w_finish) begin
      r_err     <= r_invalid;
    end
  end

  assign w_result = r_invalid ? '0 : w_bin_sh;
  assign err      = r_err;
`else
  assign w_result = w_bin_sh;
  assign err      = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_digits  <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bin_out <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_capture) begin
          r_digits <= bcd_in;
          r_bin    <= '0;
          r_cnt    <= '0;
          r_busy   <= 1'b1;
          r_state  <= ST_SHIFT;
        end
      end else begin
        r_digits <= w_digits_corr;
        r_bin    <= w_bin_sh;
        r_cnt    <= r_cnt + CNT_W'(1);
        // Result is taken from the post-shift value of the final step.
        if (w_finish) begin
          r_bin_out <= w_result;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign bin_out   = r_bin_out;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;
  localparam int DW     = 4 * DIGITS;
`ifdef BCD2BIN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [DW-1:0]    bcd_in;
  logic             busy;
  logic             done;
  logic             err;
  logic [BIN_W-1:0] bin_out;
  logic [0:0]       dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .CLOCK_50  (clk),
    .reset     (rst),
    .start     (start),
    .bcd_in    (bcd_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bin_out   (bin_out),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int bcd_value(input logic [DW-1:0] b);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v % (1 << BIN_W);
  endfunction

  function automatic bit has_bad(input logic [DW-1:0] b);
    for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] to_bcd(input int v);
    logic [DW-1:0] b;
    b[3:0]  = 4'(v % 10);
    b[7:4]  = 4'((v / 10) % 10);
    b[11:8] = 4'((v / 100) % 10);
    return b;
  endfunction

  // Scoreboard entry: {known, value}. An invalid input without the check
  // option has no defined result, so its value is not compared.
  logic [BIN_W:0] exp_q[$];
  bit m_busy, m_done, m_err, m_inv;
  int m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_err  <= 1'b0;
      m_inv  <= 1'b0;
      m_left <= 0;
      exp_q.delete();
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_err  <= m_inv && CHECK_EN;
        end
      end else if (start) begin
        m_busy <= 1'b1;
        m_left <= BIN_W;
        m_err  <= 1'b0;
        m_inv  <= has_bad(bcd_in);
        if (has_bad(bcd_in))
          exp_q.push_back({CHECK_EN, {BIN_W{1'b0}}});
        else
          exp_q.push_back({1'b1, BIN_W'(bcd_value(bcd_in))});
      end
    end
  end

  // ---------------- compare process ----------------
  logic [BIN_W-1:0] m_bin = '0;
  bit               m_bin_known = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_bin       = '0;
        m_bin_known = 1'b1;
      end else begin
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("err", err, m_err);
        check("busy_done_excl", busy & done, 1'b0);
        if (m_done) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: done with no expected entry (cycle %0d)", cyc);
          end else begin
            logic [BIN_W:0] e;
            e = exp_q.pop_front();
            m_bin_known = e[BIN_W];
            m_bin       = e[BIN_W-1:0];
            if (m_bin_known) check("bin_out_done", bin_out, m_bin);
          end
        end else if (m_bin_known) begin
          check("bin_out_hold", bin_out, m_bin);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called right after a falling edge; returns at the falling edge where done
  // is seen, with lat = number of rising edges after the accepting one.
  task automatic run_conv(input logic [DW-1:0] v, output int lat);
    bcd_in = v;
    start  = 1'b1;
    lat    = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int lat;
    int t1, t2;
    int v;

    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_bin", bin_out, 0);
    rst = 1'b0;
    @(negedge clk);

    // 255
    run_conv(12'h255, lat);
    check("lat_255", lat, 10);
    check("bin_255", bin_out, 10'h0FF);
    check("err_255", err, 1'b0);

    // boundaries
    repeat (2) @(negedge clk);
    run_conv(12'h999, lat);
    check("lat_999", lat, 10);
    check("bin_999", bin_out, 10'h3E7);
    run_conv(12'h000, lat);
    check("lat_000", lat, 10);
    check("bin_000", bin_out, 0);

    // start while busy is ignored; held start gives back-to-back conversions
    @(negedge clk);
    bcd_in = 12'h123;
    start  = 1'b1;
    t1 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3) bcd_in = 12'h456;
      if (done) begin
        t1 = cyc;
        break;
      end
    end
    check("b2b_first_seen", t1 >= 0, 1'b1);
    check("bin_123", bin_out, 10'h07B);
    t2 = -100;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        t2 = cyc;
        break;
      end
    end
    check("b2b_gap", t2 - t1, 11);
    check("bin_456", bin_out, 10'h1C8);

    // invalid digit
    repeat (3) @(negedge clk);
    run_conv(12'h1A5, lat);
    check("lat_1A5", lat, 10);
    check("err_1A5", err, CHECK_EN);
`ifdef BCD2BIN_CHECK_EN
    check("bin_1A5", bin_out, 0);
`endif
    @(negedge clk);
    check("err_held", err, CHECK_EN);

    // asynchronous reset mid-conversion
    run_conv(12'h321, lat);
    check("bin_321", bin_out, 10'd321);
    @(negedge clk);
    bcd_in = 12'h789;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_err", err, 1'b0);
    check("arst_bin", bin_out, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (12) @(negedge clk);
    check("arst_no_done", done, 1'b0);
    run_conv(12'h042, lat);
    check("lat_042", lat, 10);
    check("bin_042", bin_out, 10'd42);

    // exhaustive sweep with random gaps
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_conv(to_bcd(n), lat);
      check("sweep_lat", lat, 10);
      check("sweep_bin", bin_out, n);
    end

    // random raw words, including invalid digits
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      v = int'($urandom_range(0, 4095));
      run_conv(DW'(v), lat);
      check("rand_lat", lat, 10);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
